// File: rtl/recur_sched_if.sv
// recur_sched_if: requester, datapath and completion signals of recur_sched.
// abort/done_err exist only when RECUR_SCHED_ABORT_EN is defined.
// master = the scheduler, slave = requesters/datapath/consumer side.
interface recur_sched_if #(
    parameter int unsigned W     = 100,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 7
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*W-1:0]     req_r;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ-1:0]       gnt;
    logic                  dp_clr;
    logic                  dp_en;
    logic [W-1:0]          dp_r;
    logic [W-1:0]          dp_y;
    logic                  done_vld;
    logic                  done_rdy;
    logic [IDW-1:0]        done_id;
    logic [W-1:0]          done_y;
`ifdef RECUR_SCHED_ABORT_EN
    logic                  abort;
    logic                  done_err;
`endif

    modport master (
        input  req, req_r, req_len, dp_y, done_rdy,
`ifdef RECUR_SCHED_ABORT_EN
        input  abort,
        output done_err,
`endif
        output gnt, dp_clr, dp_en, dp_r, done_vld, done_id, done_y
    );

    modport slave (
        output req, req_r, req_len, dp_y, done_rdy,
`ifdef RECUR_SCHED_ABORT_EN
        output abort,
        input  done_err,
`endif
        input  gnt, dp_clr, dp_en, dp_r, done_vld, done_id, done_y
    );
endinterface

// File: rtl/recur_sched.sv
// recur_sched: round-robin scheduler sharing one external recurrence datapath
// (y <= 2*y + r) among NREQ requesters. Each grant clears the datapath, strobes
// it cnt_tgt times with the latched operand, then offers the result on a
// valid/ready completion port.
// Optional macro RECUR_SCHED_ABORT_EN adds abort input and done_err output.
module recur_sched #(
    parameter int unsigned W     = 100,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LEN_W = 7
) (
    input logic           clk,
    input logic           rst,
    recur_sched_if.master bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [NREQ-1:0]  gnt_q;
    logic             dp_clr_q;
    logic             dp_en_q;
    logic             done_vld_q;
    logic [W-1:0]     dp_r_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] tgt_q;
    logic             err_q;

    logic             found;
    logic [IDW-1:0]   pick;
    int               idx;
    logic [NREQ-1:0]  req_sh;
    logic [W-1:0]     pick_r;
    logic [LEN_W-1:0] pick_len;
    logic [IDW-1:0]   ptr_next;
    logic             abort_hit;

`ifdef RECUR_SCHED_ABORT_EN
    assign abort_hit    = bus.abort;
    assign bus.done_err = err_q;
`else
    assign abort_hit = 1'b0;
`endif

    // First pending request at or above the pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        idx    = 0;
        req_sh = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            req_sh = bus.req >> idx;
            if (!found && req_sh[0]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    assign pick_r   = W'(bus.req_r >> (int'(pick) * int'(W)));
    assign pick_len = LEN_W'(bus.req_len >> (int'(pick) * int'(LEN_W)));
    assign ptr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

    // Scheduler FSM; every control output is a register written here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            id_q       <= '0;
            gnt_q      <= '0;
            dp_clr_q   <= 1'b0;
            dp_en_q    <= 1'b0;
            done_vld_q <= 1'b0;
            dp_r_q     <= '0;
            cnt_q      <= '0;
            tgt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q  <= StClr;
                        id_q     <= pick;
                        gnt_q    <= NREQ'(1) << pick;
                        dp_r_q   <= pick_r;
                        tgt_q    <= pick_len;
                        dp_clr_q <= 1'b1;
                        err_q    <= 1'b0;
                    end
                end
                StClr: begin
                    dp_clr_q <= 1'b0;
                    cnt_q    <= '0;
                    if (abort_hit) begin
                        state_q    <= StDone;
                        done_vld_q <= 1'b1;
                        err_q      <= 1'b1;
                    end else if (tgt_q == '0) begin
                        state_q    <= StDone;
                        done_vld_q <= 1'b1;
                    end else begin
                        state_q <= StRun;
                        dp_en_q <= 1'b1;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    // tgt_q >= 1 here, so tgt_q - 1 cannot wrap
                    if (abort_hit || cnt_q == tgt_q - LEN_W'(1)) begin
                        state_q    <= StDone;
                        dp_en_q    <= 1'b0;
                        done_vld_q <= 1'b1;
                        err_q      <= abort_hit;
                    end
                end
                StDone: begin
                    if (bus.done_rdy) begin
                        state_q    <= StIdle;
                        gnt_q      <= '0;
                        done_vld_q <= 1'b0;
                        err_q      <= 1'b0;
                        ptr_q      <= ptr_next;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.dp_clr   = dp_clr_q;
    assign bus.dp_en    = dp_en_q;
    assign bus.dp_r     = dp_r_q;
    assign bus.done_vld = done_vld_q;
    // Datapath is frozen in StDone, so passing dp_y through keeps done_y stable.
    assign bus.done_id  = done_vld_q ? id_q : '0;
    assign bus.done_y   = done_vld_q ? bus.dp_y : '0;
endmodule

// File: tb/tb_recur_sched.sv
// tb_recur_sched: scoreboard bench for recur_sched with a behavioural datapath.
module tb_recur_sched;
    localparam int unsigned W     = 100;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned LEN_W = 7;
    localparam int unsigned IDW   = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   y;
        int             nen;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         n_vec = 0;
    int         n_err = 0;
    exp_t       exp_q[$];
    logic [W-1:0] y_model = '0;
    int         en_total = 0;
    int         clr_total = 0;

    recur_sched_if #(.W(W), .NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    recur_sched #(.W(W), .NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External accumulator the scheduler drives.
    always @(posedge clk) begin
        if (bus.dp_clr) y_model <= '0;
        else if (bus.dp_en) y_model <= {y_model[W-2:0], 1'b0} + bus.dp_r;
    end
    assign bus.dp_y = y_model;

    // Strobe counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.dp_en === 1'b1) en_total++;
        if (bus.dp_clr === 1'b1) clr_total++;
    end

    function automatic logic [W-1:0] calc_y(input logic [W-1:0] r, input int len);
        logic [W-1:0] y = '0;
        for (int k = 0; k < len; k++) y = (y << 1) + r;
        return y;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] r, input logic [LEN_W-1:0] len);
        bus.req_r[i*W +: W]           = r;
        bus.req_len[i*LEN_W +: LEN_W] = len;
    endtask

    // Returns the number of rising edges until done_vld is seen (capped).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.done_vld === 1'b1) break;
        end
    endtask

    task automatic handshake();
        bus.done_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.done_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.gnt, bus.dp_clr, bus.dp_en, bus.done_vld} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0", {bus.gnt, bus.dp_clr, bus.dp_en, bus.done_vld});
        end
        n_vec++;
        if ({bus.dp_r, bus.done_y, bus.done_id} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %0h required 0", {bus.dp_r, bus.done_y, bus.done_id});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        int cyc, en0, clr0;
        set_op(0, 1, 3);
        exp_q.push_back('{2'd0, calc_y(1, 3), 3});
        en0 = en_total; clr0 = clr_total;
        bus.req = 4'b0001;
        wait_done(cyc);
        bus.req = '0;
        e = exp_q.pop_front();
        n_vec++;
        if (cyc !== e.nen + 2) begin
            n_err++; $display("FAIL single_latency: got %0d required %0d", cyc, e.nen + 2);
        end
        n_vec++;
        if (bus.gnt !== 4'b0001) begin
            n_err++; $display("FAIL single_gnt: got %b required 0001", bus.gnt);
        end
        n_vec++;
        if (bus.done_id !== e.id) begin
            n_err++; $display("FAIL single_id: got %0d required %0d", bus.done_id, e.id);
        end
        n_vec++;
        if (bus.done_y !== e.y) begin
            n_err++; $display("FAIL single_y: got %0h required %0h", bus.done_y, e.y);
        end
        n_vec++;
        if (en_total - en0 !== e.nen) begin
            n_err++; $display("FAIL single_en: got %0d required %0d", en_total - en0, e.nen);
        end
        n_vec++;
        if (clr_total - clr0 !== 1) begin
            n_err++; $display("FAIL single_clr: got %0d required 1", clr_total - clr0);
        end
        n_vec++;
        if (bus.dp_r !== W'(1)) begin
            n_err++; $display("FAIL single_dp_r: got %0h required 1", bus.dp_r);
        end
`ifdef RECUR_SCHED_ABORT_EN
        n_vec++;
        if (bus.done_err !== 1'b0) begin
            n_err++; $display("FAIL single_err: got %b required 0", bus.done_err);
        end
`endif
        handshake();
        n_vec++;
        if ({bus.gnt, bus.done_vld} !== 5'b0) begin
            n_err++; $display("FAIL single_release: got %b required 0", {bus.gnt, bus.done_vld});
        end
    endtask

    task automatic test_zero_len();
        exp_t e;
        int cyc, en0, clr0;
        set_op(2, 9, 0);
        exp_q.push_back('{2'd2, calc_y(9, 0), 0});
        en0 = en_total; clr0 = clr_total;
        bus.req = 4'b0100;
        wait_done(cyc);
        bus.req = '0;
        e = exp_q.pop_front();
        n_vec++;
        if (cyc !== 2) begin
            n_err++; $display("FAIL zero_latency: got %0d required 2", cyc);
        end
        n_vec++;
        if ({bus.done_id, bus.done_y} !== {e.id, e.y}) begin
            n_err++; $display("FAIL zero_result: got id %0d y %0h required id %0d y %0h",
                              bus.done_id, bus.done_y, e.id, e.y);
        end
        n_vec++;
        if (en_total - en0 !== 0 || clr_total - clr0 !== 1) begin
            n_err++; $display("FAIL zero_strobes: got en %0d clr %0d required en 0 clr 1",
                              en_total - en0, clr_total - clr0);
        end
        handshake();
    endtask

    task automatic test_round_robin();
        exp_t e;
        int cyc;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, W'(i + 1), 1);
        for (int n = 0; n < 5; n++) exp_q.push_back('{IDW'(n % 4), calc_y(W'((n % 4) + 1), 1), 1});
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(cyc);
            e = exp_q.pop_front();
            n_vec++;
            if (bus.done_id !== e.id || bus.done_y !== e.y || cyc !== 3) begin
                n_err++; $display("FAIL rr_%0d: got id %0d y %0h lat %0d required id %0d y %0h lat 3",
                                  n, bus.done_id, bus.done_y, cyc, e.id, e.y);
            end
            if (n == 4) bus.req = '0;
            handshake();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int cyc;
        set_op(1, 5, 2);
        exp_q.push_back('{2'd1, calc_y(5, 2), 2});
        bus.req = 4'b0010;
        wait_done(cyc);
        bus.req = '0;
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (bus.done_vld !== 1'b1 || bus.done_y !== e.y || bus.done_id !== e.id ||
                bus.gnt !== 4'b0010) begin
                n_err++; $display("FAIL bp_hold_%0d: got vld %b y %0h id %0d gnt %b required 1 %0h %0d 0010",
                                  k, bus.done_vld, bus.done_y, bus.done_id, bus.gnt, e.y, e.id);
            end
            @(negedge clk);
        end
        bus.done_rdy = 1'b1;
        @(negedge clk);
        bus.done_rdy = 1'b0;
        n_vec++;
        if ({bus.gnt, bus.done_vld} !== 5'b0) begin
            n_err++; $display("FAIL bp_release: got %b required 0", {bus.gnt, bus.done_vld});
        end
    endtask

    task automatic test_mid_change();
        exp_t e;
        int cyc, en0;
        set_op(2, 3, 4);
        exp_q.push_back('{2'd2, calc_y(3, 4), 4});
        en0 = en_total;
        bus.req = 4'b0100;
        repeat (3) @(negedge clk);
        set_op(2, 77, 9);
        bus.req = '0;
        n_vec++;
        if (bus.dp_r !== W'(3)) begin
            n_err++; $display("FAIL mid_dp_r: got %0h required 3", bus.dp_r);
        end
        wait_done(cyc);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.done_y !== e.y || bus.done_id !== e.id || cyc + 3 !== e.nen + 2) begin
            n_err++; $display("FAIL mid_result: got y %0h id %0d lat %0d required y %0h id %0d lat %0d",
                              bus.done_y, bus.done_id, cyc + 3, e.y, e.id, e.nen + 2);
        end
        n_vec++;
        if (en_total - en0 !== e.nen) begin
            n_err++; $display("FAIL mid_en: got %0d required %0d", en_total - en0, e.nen);
        end
        handshake();
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int cyc;
        set_op(3, 1, 10);
        bus.req = 4'b1000;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.gnt, bus.dp_clr, bus.dp_en, bus.done_vld, bus.dp_r} !== '0) begin
            n_err++; $display("FAIL async_reset: got gnt %b en %b vld %b dp_r %0h required 0",
                              bus.gnt, bus.dp_en, bus.done_vld, bus.dp_r);
        end
        bus.req = '0;
        @(negedge clk);
        rst = 1'b1;
        // Pointer back at 0 means id 0 wins over id 3.
        set_op(0, 6, 0);
        set_op(3, 6, 0);
        exp_q.push_back('{2'd0, calc_y(6, 0), 0});
        bus.req = 4'b1001;
        wait_done(cyc);
        bus.req = '0;
        e = exp_q.pop_front();
        n_vec++;
        if (bus.done_id !== e.id || bus.done_y !== e.y) begin
            n_err++; $display("FAIL reset_ptr: got id %0d y %0h required id %0d y %0h",
                              bus.done_id, bus.done_y, e.id, e.y);
        end
        handshake();
    endtask

`ifdef RECUR_SCHED_ABORT_EN
    task automatic test_abort();
        exp_t e;
        int cyc, en0;
        set_op(1, 1, 10);
        exp_q.push_back('{2'd1, calc_y(1, 3), 3});
        en0 = en_total;
        bus.req = 4'b0010;
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        wait_done(cyc);
        bus.abort = 1'b0;
        bus.req = '0;
        e = exp_q.pop_front();
        n_vec++;
        if (bus.done_err !== 1'b1 || bus.done_y !== e.y || bus.done_id !== e.id || cyc !== 1) begin
            n_err++; $display("FAIL abort_result: got err %b y %0h id %0d lat %0d required 1 %0h %0d 1",
                              bus.done_err, bus.done_y, bus.done_id, cyc, e.y, e.id);
        end
        n_vec++;
        if (en_total - en0 !== e.nen) begin
            n_err++; $display("FAIL abort_en: got %0d required %0d", en_total - en0, e.nen);
        end
        handshake();
        n_vec++;
        if (bus.done_err !== 1'b0) begin
            n_err++; $display("FAIL abort_clear: got %b required 0", bus.done_err);
        end
    endtask
`endif

    initial begin
        bus.req      = '0;
        bus.req_r    = '0;
        bus.req_len  = '0;
        bus.done_rdy = 1'b0;
`ifdef RECUR_SCHED_ABORT_EN
        bus.abort    = 1'b0;
`endif
        test_reset();
        test_single();
        test_zero_len();
        test_round_robin();
        test_backpressure();
        test_mid_change();
        test_reset_mid_run();
`ifdef RECUR_SCHED_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
